// File: rtl/send_en_pkg.sv
// send_en_pkg: default sizing constants and the count-width helper shared by send_en and its FIFO
package send_en_pkg;
    localparam int N_DEF = 32;
    localparam int M_DEF = 3;
    localparam int STEP_DEF = 4;
    localparam logic [31:0] RESET_BASE_DEF = 32'd0;
    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/send_en_fifo.sv
// send_en_fifo: synchronous M-entry circular FIFO; flush beats push/pop, head reads 0 when empty
module send_en_fifo
    import send_en_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [N-1:0]        wdata,
    output logic [N-1:0]        rdata,
    output logic [cnt_w(M)-1:0] count
);
    localparam int CW = cnt_w(M);
    localparam int PW = $clog2(M);
    logic [N-1:0] mem [M];
    logic [PW-1:0] head, tail;
    always_ff @(posedge clk)
        if (push && !flush) mem[tail] <= wdata;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail == PW'(M - 1) ? '0 : tail + 1'b1;
            if (pop) head <= head == PW'(M - 1) ? '0 : head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign rdata = count != '0 ? mem[head] : '0;
endmodule

// File: rtl/send_en.sv
// send_en: sequential stream generator with M-deep output buffer and en redirect/flush
// optional SEND_EN_STALL_CNT_EN adds a saturating stall_cnt output
module send_en
    import send_en_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF,
    parameter int STEP = STEP_DEF,
    parameter logic [N-1:0] RESET_BASE = N'(RESET_BASE_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N-1:0]        data_en,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [N-1:0]        data_t,
    output logic [cnt_w(M)-1:0] count
`ifdef SEND_EN_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);
    localparam int CW = cnt_w(M);
    logic [N-1:0] gen;
    logic push, pop;
    assign out_valid = count != '0;
    // a redirect voids any handshake in its cycle
    assign pop = out_valid && out_ready && !en;
    assign push = !en && (count < CW'(M) || pop);
    always_ff @(posedge clk)
        gen <= rst ? RESET_BASE : en ? data_en : push ? gen + N'(STEP) : gen;
    send_en_fifo #(.N(N), .M(M)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(en),
        .wdata(gen),
        .rdata(data_t),
        .count(count)
    );
`ifdef SEND_EN_STALL_CNT_EN
    always_ff @(posedge clk)
        stall_cnt <= rst ? '0 : (out_valid && !out_ready && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
`endif
endmodule

// File: tb/tb_send_en.sv
// tb_send_en: directed plus random stimulus against a queue-based reference of the send_en stream
module tb_send_en;
    logic clk = 1'b0;
    logic rst, en, out_ready, out_valid;
    logic [31:0] data_en, data_t;
    logic [1:0] count;
    int checks = 0, errors = 0;
    logic [31:0] q[$];
    logic [31:0] g;
    longint unsigned sc;
`ifdef SEND_EN_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif
    always #5 clk = ~clk;
    send_en dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .data_en(data_en),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .data_t(data_t),
        .count(count)
`ifdef SEND_EN_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic r, input logic e, input logic [31:0] d, input logic rdy);
        bit popped;
        rst = r;
        en = e;
        data_en = d;
        out_ready = rdy;
        @(posedge clk);
        if (!r && q.size() != 0 && !rdy && sc != 64'hFFFF_FFFF) sc++;
        if (r) begin
            q.delete();
            g = 32'd0;
            sc = 0;
        end else if (e) begin
            q.delete();
            g = d;
        end else begin
            popped = q.size() != 0 && rdy;
            if (popped) void'(q.pop_front());
            if (q.size() < 3) begin
                q.push_back(g);
                g = g + 32'd4;
            end
        end
        #1;
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("data", data_t, q.size() != 0 ? q[0] : 32'd0);
`ifdef SEND_EN_STALL_CNT_EN
        chk("stall", stall_cnt, sc[31:0]);
`endif
    endtask
    initial begin
        sc = 0;
        g = 0;
        step(1, 0, 0, 1);
        chk("rst_count", 32'(count), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1);
            chk("seq", data_t, 32'(4 * i));
        end
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0);
            chk("fill_count", 32'(count), 32'(i < 3 ? i + 1 : 3));
            chk("fill_head", data_t, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("drain", data_t, 32'(4 * (i + 1)));
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_redir", 32'(count), 2);
        step(0, 1, 32'h100, 1);
        chk("redir_valid", 32'(out_valid), 0);
        step(0, 0, 0, 1);
        chk("redir0", data_t, 32'h100);
        step(0, 0, 0, 1);
        chk("redir1", data_t, 32'h104);
        step(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("wrap", data_t, 32'hFFFF_FFF8 + 32'(4 * i));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(1, 1, 32'h55, 0);
        chk("rst_en_count", 32'(count), 0);
        step(0, 0, 0, 1);
        chk("rst_en_base", data_t, 0);
        step(0, 1, 32'h13, 0);
        step(0, 1, 32'h27, 1);
        chk("en_hold", 32'(out_valid), 0);
        step(0, 0, 0, 1);
        chk("unaligned", data_t, 32'h27);
`ifdef SEND_EN_STALL_CNT_EN
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("stall4", stall_cnt, 4);
        step(0, 1, 32'h40, 1);
        chk("stall_en", stall_cnt, 4);
        step(1, 0, 0, 1);
        chk("stall_rst", stall_cnt, 0);
`endif
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom, 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
